// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared BCD type, digit limit and tick-divider helper.
// Revision : 1.0
// ============================================================================
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic int unsigned tick_div(input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return (tick_hz == 0) ? 0 : clk_hz / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_bcd_digit
// Purpose  : One decade cell of the BCD ripple counter (0..9, carry on 9).
// Revision : 1.0
// ============================================================================
module stopwatch_bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc_in,
    output logic [3:0] q,
    output logic       carry_out
);

    bcd_t r_q;

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc_in) begin
            r_q <= (r_q >= BCD_MAX) ? 4'd0 : r_q + 4'd1;
        end
    end

    assign q         = r_q;
    assign carry_out = inc_in & (r_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/stopwatch_lap.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_lap
// Purpose  : N-digit BCD stopwatch with prescaler, lap freeze, clear and
//            wrap-or-saturate rollover.
// Revision : 1.0
// ============================================================================
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned TICK_HZ     = 100,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter bit          STOP_AT_MAX = 1'b0
) (
    input  logic                    clk_100MHz,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    lap,
    input  logic                    clear,
    output logic [NUM_DIGITS*4-1:0] digits,
    output logic                    running,
    output logic                    lap_active,
    output logic                    wrap
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
    localparam int unsigned PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] C_PRE_LAST = PRE_W'(TICK_DIV - 1);

    generate
        if (TICK_HZ == 0 || (CLK_HZ % TICK_HZ) != 0 || TICK_DIV < 2) begin : g_bad_tick_cfg
            $error("stopwatch_lap: CLK_HZ must be a multiple of TICK_HZ with CLK_HZ/TICK_HZ >= 2");
        end
        if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digit_cfg
            $error("stopwatch_lap: NUM_DIGITS must be within 2..8");
        end
    endgenerate

    logic                    r_running;
    logic                    r_lap_active;
    logic                    r_lap_q;
    logic                    r_wrap;
    logic [PRE_W-1:0]        r_presc;
    logic [NUM_DIGITS*4-1:0] r_snap;

    logic [NUM_DIGITS*4-1:0] w_count;
    logic [NUM_DIGITS:0]     w_carry;
    logic [NUM_DIGITS-1:0]   w_is9;
    logic                    w_clr;
    logic                    w_adv;
    logic                    w_tick;
    logic                    w_all9;
    logic                    w_sat_hit;
    logic                    w_lap_rise;

    // Clear only acts on the stopped state registered before this edge.
    assign w_clr      = clear & ~r_running;
    assign w_adv      = r_running & ~stop;
    assign w_tick     = w_adv & (r_presc == C_PRE_LAST);
    assign w_all9     = &w_is9;
    assign w_sat_hit  = STOP_AT_MAX && w_tick && w_all9;
    assign w_lap_rise = lap & ~r_lap_q;
    assign w_carry[0] = w_tick & ~w_sat_hit;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            stopwatch_bcd_digit u_digit (
                .clk_100MHz (clk_100MHz),
                .reset_n    (reset_n),
                .clr        (w_clr),
                .inc_in     (w_carry[i]),
                .q          (w_count[i*4 +: 4]),
                .carry_out  (w_carry[i+1])
            );
            assign w_is9[i] = (w_count[i*4 +: 4] == BCD_MAX);
        end
    endgenerate

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_running <= 1'b0;
        end else if (w_sat_hit || stop) begin
            r_running <= 1'b0;
        end else if (start) begin
            r_running <= 1'b1;
        end
    end

    // Prescaler holds while stopped so a resumed partial tick is kept.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_clr || w_sat_hit) begin
            r_presc <= '0;
        end else if (w_adv) begin
            r_presc <= (r_presc == C_PRE_LAST) ? '0 : r_presc + PRE_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[NUM_DIGITS];
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_lap_q      <= 1'b0;
            r_lap_active <= 1'b0;
            r_snap       <= '0;
        end else begin
            r_lap_q <= lap;
            if (w_clr) begin
                r_lap_active <= 1'b0;
            end else if (w_lap_rise) begin
                if (!r_lap_active) begin
                    r_snap       <= w_count;
                    r_lap_active <= 1'b1;
                end else begin
                    r_lap_active <= 1'b0;
                end
            end
        end
    end

    assign digits     = r_lap_active ? r_snap : w_count;
    assign running    = r_running;
    assign lap_active = r_lap_active;
    assign wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_lap
// Purpose  : Scoreboard bench for stopwatch_lap: 4-digit wrap, 2-digit wrap
//            and 2-digit saturating instances against an integer model.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_stopwatch_lap;

    localparam int TICK_DIV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic stop    = 1'b0;
    logic lap     = 1'b0;
    logic clear   = 1'b0;

    logic [15:0] dig0;
    logic [7:0]  dig1;
    logic [7:0]  dig2;
    logic [2:0]  run_o;
    logic [2:0]  lapa_o;
    logic [2:0]  wrap_o;

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(4), .STOP_AT_MAX(1'b0)) u_dut4 (
        .clk_100MHz(clk), .reset_n(reset_n), .start(start), .stop(stop), .lap(lap), .clear(clear),
        .digits(dig0), .running(run_o[0]), .lap_active(lapa_o[0]), .wrap(wrap_o[0]));

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(2), .STOP_AT_MAX(1'b0)) u_dut2w (
        .clk_100MHz(clk), .reset_n(reset_n), .start(start), .stop(stop), .lap(lap), .clear(clear),
        .digits(dig1), .running(run_o[1]), .lap_active(lapa_o[1]), .wrap(wrap_o[1]));

    stopwatch_lap #(.CLK_HZ(1000), .TICK_HZ(100), .NUM_DIGITS(2), .STOP_AT_MAX(1'b1)) u_dut2s (
        .clk_100MHz(clk), .reset_n(reset_n), .start(start), .stop(stop), .lap(lap), .clear(clear),
        .digits(dig2), .running(run_o[2]), .lap_active(lapa_o[2]), .wrap(wrap_o[2]));

    typedef struct packed {
        logic [15:0] d0;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [2:0]  run;
        logic [2:0]  lapa;
        logic [2:0]  wrap;
    } exp_t;

    exp_t q_exp[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: integer count, integer prescaler phase.
    int MAXV[3] = '{9999, 99, 99};
    bit SAT[3]  = '{1'b0, 1'b0, 1'b1};
    int m_cnt[3], m_pre[3], m_snap[3];
    bit m_run[3], m_lapa[3], m_lapq[3], m_wrap[3];

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            bit clr, tick, hit, rise;
            int old_cnt;
            if (!reset_n) begin
                m_cnt[k] = 0; m_pre[k] = 0; m_snap[k] = 0;
                m_run[k] = 0; m_lapa[k] = 0; m_lapq[k] = 0; m_wrap[k] = 0;
            end else begin
                old_cnt = m_cnt[k];
                clr  = clear && !m_run[k];
                tick = m_run[k] && !stop && (m_pre[k] == TICK_DIV - 1);
                hit  = tick && SAT[k] && (old_cnt == MAXV[k]);
                rise = lap && !m_lapq[k];
                m_wrap[k] = 1'b0;
                if (clr || hit)
                    m_pre[k] = 0;
                else if (m_run[k] && !stop)
                    m_pre[k] = (m_pre[k] + 1) % TICK_DIV;
                if (clr) begin
                    m_cnt[k] = 0;
                end else if (tick && !hit) begin
                    m_cnt[k]  = (old_cnt + 1) % (MAXV[k] + 1);
                    m_wrap[k] = (old_cnt == MAXV[k]);
                end
                if (clr) begin
                    m_lapa[k] = 1'b0;
                end else if (rise) begin
                    if (!m_lapa[k]) begin
                        m_snap[k] = old_cnt;
                        m_lapa[k] = 1'b1;
                    end else begin
                        m_lapa[k] = 1'b0;
                    end
                end
                m_lapq[k] = lap;
                if (hit || stop)
                    m_run[k] = 1'b0;
                else if (start)
                    m_run[k] = 1'b1;
            end
        end
    endtask

    task automatic push_exp();
        exp_t        e;
        logic [31:0] b;
        b = to_bcd(m_lapa[0] ? m_snap[0] : m_cnt[0]); e.d0 = b[15:0];
        b = to_bcd(m_lapa[1] ? m_snap[1] : m_cnt[1]); e.d1 = b[7:0];
        b = to_bcd(m_lapa[2] ? m_snap[2] : m_cnt[2]); e.d2 = b[7:0];
        e.run  = {m_run[2],  m_run[1],  m_run[0]};
        e.lapa = {m_lapa[2], m_lapa[1], m_lapa[0]};
        e.wrap = {m_wrap[2], m_wrap[1], m_wrap[0]};
        q_exp.push_back(e);
    endtask

    task automatic cycle(input logic rn, input logic s, input logic p,
                         input logic l, input logic c);
        @(negedge clk);
        reset_n = rn; start = s; stop = p; lap = l; clear = c;
        @(posedge clk);
        model_step();
        push_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic lap_pulse();
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            chk("digits_4d",     32'(dig0),   32'(e.d0));
            chk("digits_2d_wrap", 32'(dig1),  32'(e.d1));
            chk("digits_2d_sat", 32'(dig2),   32'(e.d2));
            chk("running",       32'(run_o),  32'(e.run));
            chk("lap_active",    32'(lapa_o), 32'(e.lapa));
            chk("wrap",          32'(wrap_o), 32'(e.wrap));
        end
    end

    initial begin
        int guard;
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start pulse then long run: 2-digit instances reach 99 and roll/saturate.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1010);

        // Stop mid-prescale, hold, resume.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(50);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(25);

        // Lap freeze across 300 cycles, then release.
        lap_pulse();
        idle(300);
        lap_pulse();
        idle(5);

        // Clear while running (ignored), then stopped clear, then start+clear.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        lap_pulse();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(30);

        // Reset mid-lap, then simultaneous start and stop.
        lap_pulse();
        idle(12);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(15);

        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 499) != 0),
                  ($urandom_range(0, 7)   == 0),
                  ($urandom_range(0, 23)  == 0),
                  ($urandom_range(0, 9)   == 0),
                  ($urandom_range(0, 15)  == 0));
        end

        guard = 0;
        while (q_exp.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        if (q_exp.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
